// File: rtl/proj_fm_mbuf_ram.sv
// proj_fm_mbuf_ram: N-way rotating feature-map buffer. Producer fills buffers in order under
// valid/ready; consumer reads the oldest committed buffer on parallel ports and releases it.
// Optional macro PROJ_FM_RDATA_REG_EN adds a second read output register (read latency 2).
module proj_fm_mbuf_ram #(
    parameter int BUFFER_COUNT         = 2,
    parameter int RAMS                 = 2,
    parameter int ENTRIES              = 2,
    parameter int OFFSET               = 2,
    parameter int DATA_BITS            = 8,
    parameter int READ_ADDRESSES_COUNT = 4,
    localparam int DEPTH = RAMS * ENTRIES * OFFSET,
    localparam int AW    = (DEPTH > 2) ? $clog2(DEPTH) : 1,
    localparam int BW    = (BUFFER_COUNT > 2) ? $clog2(BUFFER_COUNT) : 1
) (
    input  logic                                        in_clk,
    input  logic                                        in_rst_n,
    input  logic                                        in_wvalid,
    input  logic [DATA_BITS-1:0]                        in_wdata,
    output logic                                        out_wready,
    input  logic                                        in_rreq,
    input  logic [READ_ADDRESSES_COUNT*AW-1:0]          in_raddr,
    input  logic                                        in_rdone,
    output logic                                        out_rvalid,
    output logic [READ_ADDRESSES_COUNT*DATA_BITS-1:0]   out_rdata,
    output logic                                        out_rd_avail,
    output logic [BW:0]                                 out_full_cnt
);

    localparam int RDW = READ_ADDRESSES_COUNT * DATA_BITS;

    logic [DATA_BITS-1:0] mem_r [BUFFER_COUNT][DEPTH];
    logic [BW-1:0]        wr_idx_r;
    logic [BW-1:0]        rd_idx_r;
    logic [AW-1:0]        wr_ptr_r;
    logic [BW:0]          full_cnt_r;
    logic                 rvalid_r;
    logic [RDW-1:0]       rdata_r;

    logic                 wready_s;
    logic                 rd_avail_s;
    logic                 accept_s;
    logic                 commit_s;
    logic                 rd_fire_s;
    logic                 release_s;
    logic [BW:0]          full_cnt_nxt_s;
    logic [RDW-1:0]       rdata_nxt_s;

    function automatic logic [BW-1:0] idx_inc(input logic [BW-1:0] idx);
        if (idx == BW'(BUFFER_COUNT - 1)) begin
            idx_inc = '0;
        end else begin
            idx_inc = idx + BW'(1);
        end
    endfunction

    // Handshake qualifiers, all derived from registered occupancy (no rdone->wready path)
    always_comb begin
        wready_s   = (full_cnt_r < (BW+1)'(BUFFER_COUNT));
        rd_avail_s = (full_cnt_r != '0);
        accept_s   = in_wvalid & wready_s;
        commit_s   = accept_s & (wr_ptr_r == AW'(DEPTH - 1));
        rd_fire_s  = in_rreq & rd_avail_s;
        release_s  = in_rdone & rd_avail_s;
    end

    // Occupancy update: commit and release in the same cycle cancel out
    always_comb begin
        case ({commit_s, release_s})
            2'b10:   full_cnt_nxt_s = full_cnt_r + (BW+1)'(1);
            2'b01:   full_cnt_nxt_s = full_cnt_r - (BW+1)'(1);
            default: full_cnt_nxt_s = full_cnt_r;
        endcase
    end

    // Parallel read mux from the oldest committed buffer; out-of-range ports read zero
    always_comb begin
        rdata_nxt_s = '0;
        for (int k = 0; k < READ_ADDRESSES_COUNT; k++) begin
            if (int'(in_raddr[k*AW +: AW]) < DEPTH) begin
                rdata_nxt_s[k*DATA_BITS +: DATA_BITS] = mem_r[rd_idx_r][in_raddr[k*AW +: AW]];
            end else begin
                rdata_nxt_s[k*DATA_BITS +: DATA_BITS] = '0;
            end
        end
    end

    // Buffer rotation state: write pointer, buffer indices and occupancy
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            wr_idx_r   <= '0;
            rd_idx_r   <= '0;
            wr_ptr_r   <= '0;
            full_cnt_r <= '0;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= commit_s ? '0 : wr_ptr_r + AW'(1);
            end
            if (commit_s) begin
                wr_idx_r <= idx_inc(wr_idx_r);
            end
            if (release_s) begin
                rd_idx_r <= idx_inc(rd_idx_r);
            end
            full_cnt_r <= full_cnt_nxt_s;
        end
    end

    // Storage array; contents survive reset by design
    always_ff @(posedge in_clk) begin
        if (accept_s) begin
            mem_r[wr_idx_r][wr_ptr_r] <= in_wdata;
        end
    end

    // First read output stage: data captured before any same-cycle release takes effect
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            rvalid_r <= 1'b0;
            rdata_r  <= '0;
        end else begin
            rvalid_r <= rd_fire_s;
            if (rd_fire_s) begin
                rdata_r <= rdata_nxt_s;
            end
        end
    end

`ifdef PROJ_FM_RDATA_REG_EN
    logic           rvalid2_r;
    logic [RDW-1:0] rdata2_r;

    // Second output stage keeps valid and data aligned
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            rvalid2_r <= 1'b0;
            rdata2_r  <= '0;
        end else begin
            rvalid2_r <= rvalid_r;
            rdata2_r  <= rdata_r;
        end
    end

    assign out_rvalid = rvalid2_r;
    assign out_rdata  = rdata2_r;
`else
    assign out_rvalid = rvalid_r;
    assign out_rdata  = rdata_r;
`endif

    assign out_wready   = wready_s;
    assign out_rd_avail = rd_avail_s;
    assign out_full_cnt = full_cnt_r;

endmodule

// File: tb/tb_proj_fm_mbuf_ram.sv
// Bench for proj_fm_mbuf_ram: table vectors, directed corner sequences and random traffic
// checked against a frame-queue reference model.
module tb_proj_fm_mbuf_ram;
    localparam int BC    = 2;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int RA    = 4;
    localparam int DB    = 8;
    localparam int AW2   = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wvalid, wready, rreq, rdone, rvalid, rd_avail;
    logic [DB-1:0]     wdata;
    logic [RA*AW-1:0]  raddr;
    logic [RA*DB-1:0]  rdata;
    logic [1:0]        full_cnt;

    logic              w2valid, w2ready, r2req, r2done, r2valid, rd2_avail;
    logic [DB-1:0]     w2data;
    logic [RA*AW2-1:0] r2addr;
    logic [RA*DB-1:0]  r2data;
    logic [1:0]        full2_cnt;

    always #5 clk = ~clk;

    proj_fm_mbuf_ram dut (
        .in_clk(clk), .in_rst_n(rst_n), .in_wvalid(wvalid), .in_wdata(wdata),
        .out_wready(wready), .in_rreq(rreq), .in_raddr(raddr), .in_rdone(rdone),
        .out_rvalid(rvalid), .out_rdata(rdata), .out_rd_avail(rd_avail),
        .out_full_cnt(full_cnt)
    );

    // Depth 12 instance so that out-of-range addresses are expressible
    proj_fm_mbuf_ram #(.ENTRIES(3)) dut2 (
        .in_clk(clk), .in_rst_n(rst_n), .in_wvalid(w2valid), .in_wdata(w2data),
        .out_wready(w2ready), .in_rreq(r2req), .in_raddr(r2addr), .in_rdone(r2done),
        .out_rvalid(r2valid), .out_rdata(r2data), .out_rd_avail(rd2_avail),
        .out_full_cnt(full2_cnt)
    );

    // Reference model: queue of committed frames plus the frame being filled
    logic [DEPTH*DB-1:0] fq[$];
    logic [DEPTH*DB-1:0] cur_frame;
    int                  cur_n;
    logic                s1_v, exp_rvalid;
    logic [RA*DB-1:0]    s1_d, exp_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic             wv;
        logic [DB-1:0]    wd;
        logic             rq;
        logic [RA*AW-1:0] ra;
        logic             rd;
        logic             e_wready;
        logic             e_avail;
        logic [1:0]       e_cnt;
        logic             e_rvalid;
        logic [RA*DB-1:0] e_rdata;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        fq.delete();
        cur_n      = 0;
        cur_frame  = '0;
        s1_v       = 1'b0;
        s1_d       = '0;
        exp_rvalid = 1'b0;
        exp_rdata  = '0;
    endtask

    task automatic step(input logic wv, input logic [DB-1:0] wd, input logic rq,
                        input logic [RA*AW-1:0] ra, input logic rd);
        logic             avail, space, nv;
        logic [RA*DB-1:0] nd;
        logic [DEPTH*DB-1:0] fr;
        int               a;
        chk("wready", wready, fq.size() < BC);
        chk("rd_avail", rd_avail, fq.size() != 0);
        chk("full_cnt", full_cnt, fq.size());
        chk("rvalid", rvalid, exp_rvalid);
        chk("rdata", rdata, exp_rdata);
        wvalid = wv; wdata = wd; rreq = rq; raddr = ra; rdone = rd;
        avail = (fq.size() != 0);
        space = (fq.size() < BC);
        nv    = rq & avail;
        nd    = s1_d;
        if (nv) begin
            fr = fq[0];
            for (int k = 0; k < RA; k++) begin
                a = int'(ra[k*AW +: AW]);
                nd[k*DB +: DB] = (a < DEPTH) ? fr[a*DB +: DB] : 8'h00;
            end
        end
        if (wv && space) begin
            cur_frame[cur_n*DB +: DB] = wd;
            cur_n++;
            if (cur_n == DEPTH) begin
                fq.push_back(cur_frame);
                cur_n = 0;
            end
        end
        if (rd && avail) begin
            fr = fq.pop_front();
        end
`ifdef PROJ_FM_RDATA_REG_EN
        exp_rvalid = s1_v;
        exp_rdata  = s1_d;
`endif
        s1_v = nv;
        s1_d = nd;
`ifndef PROJ_FM_RDATA_REG_EN
        exp_rvalid = s1_v;
        exp_rdata  = s1_d;
`endif
        @(posedge clk); #1;
        wvalid = 1'b0; rreq = 1'b0; rdone = 1'b0;
    endtask

    task automatic do_reset();
        wvalid = 1'b0; rreq = 1'b0; rdone = 1'b0; raddr = '0; wdata = '0;
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("rst_full_cnt", full_cnt, 64'd0);
        chk("rst_rvalid", rvalid, 64'd0);
        chk("rst_wready", wready, 64'd1);
        chk("rst_rd_avail", rd_avail, 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic write_words(input logic [DB-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 8'(base + 8'(i)), 1'b0, '0, 1'b0);
        end
    endtask

    task automatic read_frame_release();
        step(1'b0, 8'h00, 1'b1, {3'd3, 3'd2, 3'd1, 3'd0}, 1'b0);
        step(1'b0, 8'h00, 1'b1, {3'd7, 3'd6, 3'd5, 3'd4}, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        wvalid = 1'b0; wdata = '0; rreq = 1'b0; raddr = '0; rdone = 1'b0;
        w2valid = 1'b0; w2data = '0; r2req = 1'b0; r2addr = '0; r2done = 1'b0;
        #6;
        do_reset();

        // Out-of-range ports on the depth-12 instance
        for (int i = 0; i < 12; i++) begin
            w2valid = 1'b1; w2data = 8'(8'h40 + 8'(i));
            @(posedge clk); #1;
        end
        w2valid = 1'b0;
        chk("oor_full_cnt", full2_cnt, 64'd1);
        r2req = 1'b1; r2addr = {4'd11, 4'd9, 4'd15, 4'd12};
        @(posedge clk); #1;
        r2req = 1'b0;
`ifdef PROJ_FM_RDATA_REG_EN
        @(posedge clk); #1;
`endif
        chk("oor_rvalid", r2valid, 64'd1);
        chk("oor_rdata", r2data, 64'h4B490000);

        // Table: first frame 0x00..0x07 then a four-port read
        for (int i = 0; i < 8; i++) begin
            vt[i] = '{1'b1, 8'(i), 1'b0, 12'h000, 1'b0,
                      1'b1, (i == 7), (i == 7) ? 2'd1 : 2'd0, 1'b0, 32'h0};
        end
        vt[8] = '{1'b0, 8'h00, 1'b1, {3'd0, 3'd2, 3'd5, 3'd7}, 1'b0,
                  1'b1, 1'b1, 2'd1, 1'b1, 32'h00020507};
        vt[9] = '{1'b0, 8'h00, 1'b0, 12'h000, 1'b0,
                  1'b1, 1'b1, 2'd1, 1'b0, 32'h00020507};
        for (int i = 0; i < 10; i++) begin
            step(vt[i].wv, vt[i].wd, vt[i].rq, vt[i].ra, vt[i].rd);
            chk("tbl_wready", wready, vt[i].e_wready);
            chk("tbl_rd_avail", rd_avail, vt[i].e_avail);
            chk("tbl_full_cnt", full_cnt, vt[i].e_cnt);
`ifndef PROJ_FM_RDATA_REG_EN
            chk("tbl_rvalid", rvalid, vt[i].e_rvalid);
            chk("tbl_rdata", rdata, vt[i].e_rdata);
`endif
        end

        // Back-pressure: two full buffers stall the 17th word until a release
        do_reset();
        write_words(8'h10, 16);
        chk("stall_wready", wready, 64'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'hAA, 1'b0, '0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, '0, 1'b1);
        chk("stall_wready_after_rdone", wready, 64'd1);
        step(1'b1, 8'hAA, 1'b0, '0, 1'b0);
        write_words(8'hB1, 7);
        read_frame_release();
        read_frame_release();
        step(1'b0, 8'h00, 1'b0, '0, 1'b0);

        // Commit and release in the same cycle
        do_reset();
        write_words(8'h20, 8);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 8'(8'h30 + 8'(i)), 1'b1, 12'($urandom), 1'b0);
        end
        step(1'b1, 8'h37, 1'b1, {3'd7, 3'd6, 3'd1, 3'd0}, 1'b1);
        chk("simul_full_cnt", full_cnt, 64'd1);
        read_frame_release();
        step(1'b0, 8'h00, 1'b0, '0, 1'b0);

        // Requests and releases while empty are ignored
        step(1'b0, 8'h00, 1'b1, {3'd1, 3'd2, 3'd3, 3'd4}, 1'b1);
        step(1'b0, 8'h00, 1'b0, '0, 1'b0);
        chk("empty_rvalid", rvalid, 64'd0);
        chk("empty_full_cnt", full_cnt, 64'd0);

        // Eight frames through the index wrap
        for (int f = 0; f < 8; f++) begin
            write_words(8'(8 * f), 8);
            read_frame_release();
        end
        step(1'b0, 8'h00, 1'b0, '0, 1'b0);

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            step($urandom_range(3, 0) != 0, 8'($urandom), $urandom_range(1, 0) == 1,
                 12'($urandom), $urandom_range(7, 0) == 0);
        end

        // Reset in the middle of filling buffer1
        do_reset();
        write_words(8'h50, 8);
        write_words(8'h58, 5);
        do_reset();
        write_words(8'h60, 8);
        read_frame_release();
        step(1'b0, 8'h00, 1'b0, '0, 1'b0);
        step(1'b0, 8'h00, 1'b0, '0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
